seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_pkg.sv | 36 +++
 rtl/seg_decode.sv | 13 +
 rtl/seg_scan.sv | 115 +++++++++++
 tb/tb_seg_scan.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low segment font and blank code.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg_pkg;

  // Active-low segment patterns, bits 6:0 = g,f,e,d,c,b,a
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Lookup table indexed by nibble value
  localparam logic [15:0][6:0] SEG_LUT = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  // All segments including dp off
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Segments 6:0 off, used for suppressed leading zeros
  localparam logic [6:0] SEG_OFF7 = 7'h7F;

endpackage

// File: rtl/seg_decode.sv
// Nibble to active-low seven-segment pattern (hex font, 0-9 and A-F).
// Latency: combinational, 0 cycles.
// Backpressure: none.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner: shadow-registered digits, per-slot blanking, active-low outputs.
// Latency: seg/sel registered, 1 cycle after prescaler/index/shadow state; load captured every cycle it is high.
// Backpressure: none; LEADING_ZERO_BLANK_EN suppresses leading-zero digits (k>0) when defined.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   data_q;
  logic [DIGITS-1:0]     dp_q;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     sel_q, sel_d;

  logic [3:0]            cur_nib;
  logic [6:0]            cur_font;
  logic                  upper_zero;
  logic                  in_blank;

  // Prescaler wraps every SCAN_DIV cycles; the digit index steps on each wrap
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Prescaler and digit index state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Shadow registers: the display only ever reads these, never data_in
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      dp_q   <= '0;
    end else if (load) begin
      data_q <= data_in;
      dp_q   <= dp_in;
    end
  end

  assign cur_nib    = data_q[{idx_q, 2'b00} +: 4];
  assign upper_zero = ((data_q >> {idx_q, 2'b00}) == '0);
  assign in_blank   = (cnt_q < CW'(BLANK_CYCLES));

  seg_decode u_decode (
    .nib_i (cur_nib),
    .seg_o (cur_font)
  );

  // Next output pattern from the current prescaler, index and shadow state
  always_comb begin
    seg_d = SEG_BLANK;
    sel_d = '1;
    if (!in_blank) begin
      sel_d = ~(DIGITS'(1) << idx_q);
`ifdef LEADING_ZERO_BLANK_EN
      // Digit 0 always shows, so a value of zero still displays "0"
      if ((idx_q != '0) && upper_zero) begin
        seg_d = {~dp_q[idx_q], SEG_OFF7};
      end else begin
        seg_d = {~dp_q[idx_q], cur_font};
      end
`else
      seg_d = {~dp_q[idx_q], cur_font};
`endif
    end
  end

`ifndef LEADING_ZERO_BLANK_EN
  // Leading-zero detection only feeds the optional suppression path
  logic unused_upper_zero;
  assign unused_upper_zero = upper_zero;
`endif

  // Registered outputs, forced blank while in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
      sel_q <= '1;
    end else begin
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
  end

  assign seg = seg_q;
  assign sel = sel_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan with DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
// Reference model derives outputs from elapsed cycles since reset and the captured shadow value.
// Directed literal checks pin the scan order, dp, mid-slot load and reset priority.
module tb_seg_scan;

  localparam int D  = 4;
  localparam int SD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [7:0]  seg;
  logic [3:0]  sel;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg_scan #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data_in (data_in),
    .dp_in   (dp_in),
    .seg     (seg),
    .sel     (sel)
  );

  // Font as written in the decode table, active-low g..a
  logic [6:0] ref_font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: cycles since reset release and the captured shadow values
  int          m_t = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0;
  logic [11:0] exp_out = 12'hFFF;
  logic        m_valid = 1'b0;

  function automatic logic [11:0] expect_out(int t, logic [15:0] d, logic [3:0] p);
    int         pos;
    int         dig;
    logic [3:0] nib;
    logic [6:0] f;
    logic [3:0] s;
    pos = t % SD;
    dig = (t / SD) % D;
    if (pos < BC) return 12'hFFF;
    nib = 4'(d >> (4 * dig));
    f   = ref_font[nib];
`ifdef LEADING_ZERO_BLANK_EN
    if (dig > 0 && (d >> (4 * dig)) == 16'h0) f = 7'h7F;
`endif
    s = 4'hF;
    s[dig] = 1'b0;
    return {s, ~p[dig], f};
  endfunction

  // Reference model advances on each rising edge
  always @(posedge clk) begin
    if (rst) exp_out <= 12'hFFF;
    else     exp_out <= expect_out(m_t, m_data, m_dp);
    if (rst) begin
      m_t    <= 0;
      m_data <= '0;
      m_dp   <= '0;
    end else begin
      m_t <= m_t + 1;
      if (load) begin
        m_data <= data_in;
        m_dp   <= dp_in;
      end
    end
    m_valid <= 1'b1;
  end

  // Every-cycle comparison against the model, plus the one-digit-active rule
  always @(negedge clk) begin
    if (m_valid) begin
      n_vec++;
      if ({sel, seg} !== exp_out) begin
        n_err++;
        $display("FAIL model t=%0t: sel=%b seg=%h, expected sel=%b seg=%h",
                 $time, sel, seg, exp_out[11:8], exp_out[7:0]);
      end
      n_vec++;
      if ($countones(~sel) > 1) begin
        n_err++;
        $display("FAIL onehot t=%0t: sel=%b has more than one low bit", $time, sel);
      end
    end
  end

  task automatic lit(input string name, input logic [3:0] es, input logic [7:0] eg);
    n_vec++;
    if (sel !== es || seg !== eg) begin
      n_err++;
      $display("FAIL %s: sel=%b seg=%h, expected sel=%b seg=%h", name, sel, seg, es, eg);
    end
  endtask

  // Wait for the first lit cycle of digit 0 showing eg; returns at that negedge
  task automatic wait_slot0(input string name, input logic [7:0] eg);
    bit prev_blank = 1'b0;
    bit found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (prev_blank && sel == 4'hE && seg == eg) found = 1'b1;
      prev_blank = (sel == 4'hF);
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout waiting for digit 0 seg=%h, last sel=%b seg=%h", name, eg, sel, seg);
    end
  endtask

  // Walk one full 32-cycle frame starting at the first lit cycle of digit 0
  task automatic check_frame(input string name, input logic [3:0][7:0] g);
    for (int d = 0; d < D; d++) begin
      for (int k = 0; k < SD - BC; k++) begin
        if (d != 0 || k != 0) @(negedge clk);
        lit(name, ~(4'(1) << d), g[d]);
      end
      for (int b = 0; b < BC; b++) begin
        @(negedge clk);
        lit(name, 4'hF, 8'hFF);
      end
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    @(posedge clk); #1;
    load = 1'b1; data_in = d; dp_in = p;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  initial begin
    int  blanks;
    bit  found;

    // Reset hold, then count blank cycles before the first lit output
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    blanks = 0;
    found  = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (sel == 4'hF && seg == 8'hFF) blanks++;
      else found = 1'b1;
    end
    lit("reset_first_lit", 4'hE, 8'hC0);
    n_vec++;
    if (blanks != 3) begin
      n_err++;
      $display("FAIL reset_blank_count: saw %0d blank samples, expected 3", blanks);
    end

    // Scan order with 1234
    do_load(16'h1234, 4'b0000);
    wait_slot0("scan_1234", 8'h99);
    check_frame("scan_1234", {8'hF9, 8'hA4, 8'hB0, 8'h99});

    // Decimal point and leading zeros
    do_load(16'h0009, 4'b0001);
    wait_slot0("dp_0009", 8'h10);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame("dp_0009", {8'hFF, 8'hFF, 8'hFF, 8'h10});
`else
    check_frame("dp_0009", {8'hC0, 8'hC0, 8'hC0, 8'h10});
`endif

    // Hex digits with a load during the 4th lit cycle of digit 0
    do_load(16'hABCF, 4'b0000);
    wait_slot0("hex_abcf", 8'h8E);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    load = 1'b1; data_in = 16'h5678; dp_in = 4'b0000;
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    lit("midslot_before", 4'hE, 8'h8E);
    @(negedge clk);
    lit("midslot_after", 4'hE, 8'h80);

    // Reset wins over a simultaneous load
    @(posedge clk); #1;
    rst = 1'b1; load = 1'b1; data_in = 16'h8888;
    @(posedge clk); #1;
    rst = 1'b0; load = 1'b0;
    wait_slot0("rst_priority", 8'hC0);
    lit("rst_priority", 4'hE, 8'hC0);

    // Randomized loads, data and occasional resets, checked every cycle
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst     = ($urandom_range(0, 299) == 0);
      load    = ($urandom_range(0, 11) == 0);
      data_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in   = 4'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b0; load = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
